parity_rx: RTL and testbench
============================

// Module: parity_rx
// PURPOSE
//   Serial frame receiver and XOR-parity checker. It is the receive end of the
//   parity-protected serial link whose transmitter builds the parity bit by XOR-reducing the data.
//   Frame format: start bit, DATA_W data bits sent LSB first, one parity bit, one stop bit.
//   The block oversamples the line, deserialises the frame and checks parity and stop bit.
//   It presents each word on a valid/ready interface to downstream logic.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; minimum 4, must be even
//   DATA_W        8   data bits per frame; range 1..16
//   ODD_PARITY    0   0 = even parity (XOR of data and parity = 0); 1 = odd parity
// PORTS
//   clk         in   1       single clock; all logic on its rising edge
//   reset       in   1       synchronous reset, active-high
//   rx_serial   in   1       asynchronous serial line; idles high
//   rx_data     out  DATA_W  received word; valid while rx_valid=1
//   rx_valid    out  1       word available
//   rx_ready    in   1       downstream accepts; transfer happens when rx_valid && rx_ready
//   parity_err  out  1       parity mismatch on the current word; qualified by rx_valid
//   frame_err   out  1       stop bit sampled low on the current word; qualified by rx_valid
//   overrun     out  1       one-cycle pulse when a finished frame is dropped
//   busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; rx_data=0; rx_valid, parity_err, frame_err, overrun, busy all 0.
//     Synchroniser and edge-detect history are preset to 1 (line idle).
//   - Reset wins over every other event, including a frame in progress. The partial frame is
//     discarded and no output is produced.
//   - rx_serial passes through a 2-FF synchroniser (2 clk latency) before any use.
//   - A start is detected only on a 1->0 transition of the synchronised line. A line held low
//     (break) cannot retrigger reception.
//   - FSM (bit counter 0..CLKS_PER_BIT-1, data bit index 0..DATA_W-1):
//     IDLE   -> START on a detected falling edge; bit counter cleared.
//     START  -> sample at count CLKS_PER_BIT/2-1. If the line is 1, treat as a glitch and return
//               to IDLE with no output. If 0, go to DATA with the counter cleared.
//     DATA   -> sample every CLKS_PER_BIT cycles, i.e. at mid-bit. Shift each bit in LSB first and
//               XOR it into the parity accumulator. Go to PARITY after DATA_W bits.
//     PARITY -> sample one bit; perr = acc ^ bit ^ ODD_PARITY. Go to STOP.
//     STOP   -> sample the stop bit; ferr = ~bit. Go to IDLE in the same cycle, so the next start
//               edge is accepted from mid-stop onward.
//   - Output load happens in the cycle after the stop-bit sample:
//     - If rx_valid=0, or rx_valid=1 with rx_ready=1 in that cycle: load rx_data, parity_err and
//       frame_err, and set rx_valid=1.
//     - If rx_valid=1 and rx_ready=0: the new frame is dropped, the held word and flags are
//       unchanged, and overrun pulses high for exactly 1 cycle.
//   - rx_valid is cleared one cycle after a handshake, unless a new word loads in that same cycle.
//   - rx_data and the flags stay stable while rx_valid=1 and rx_ready=0.
//   - Words with parity_err or frame_err set are still delivered; the flags travel with the word.
//   - Latency: rx_valid rises 1 clk after the stop-bit mid sample, about 2 + 0.5 + (DATA_W+2) bit
//     times after the start edge on rx_serial.
// STRUCTURE
//   - Shared package parity_pkg: FSM state encodings (IDLE, START, DATA, PARITY, STOP) and the
//     frame-format constants. The matching transmitter uses the same package.
//   - Sub-module bit_sync: generic 2-FF synchroniser with a reset preset value. This block
//     instantiates it with preset 1.
//   - Counters, shift register and parity accumulator stay inline in parity_rx.
// TESTING (CLKS_PER_BIT=16, DATA_W=8, ODD_PARITY=0 unless noted)
//   1. Frame 0xA5, parity bit 0, stop bit 1, rx_ready=1 -> rx_data=0xA5, rx_valid for 1 clk,
//      parity_err=0, frame_err=0.
//   2. Frame 0xA5 with parity bit 1 -> rx_data=0xA5, parity_err=1, frame_err=0.
//      Repeat with ODD_PARITY=1 -> parity_err=0.
//   3. Frame 0x3C with stop bit 0, then line returns high -> frame_err=1. The next frame 0x01
//      sent after the line is high is received cleanly.
//   4. 4-clk low glitch on an idle line -> no rx_valid, busy returns to 0 within 10 clks.
//      A 0x00 break held for 20 bit times -> exactly one word with frame_err=1.
//   5. rx_ready=0; frames 0x3C then 0x5A sent back to back -> rx_data stays 0x3C and one overrun
//      pulse occurs. After rx_ready=1, rx_valid drops for 1 clk.
//   6. Reset asserted for 1 clk during data bit 3 of 0xFF -> all outputs 0 and no word.
//      The following frame 0x0F gives rx_data=0x0F with both flags 0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity-protected serial link (receiver and transmitter).
// Holds the FSM state encoding and the frame-format constants.
package parity_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int   DEF_CLKS_PER_BIT = 16;
   localparam int   DEF_DATA_W       = 8;
   localparam int   MAX_DATA_W       = 16;
   localparam logic IDLE_LEVEL       = 1'b1;
   localparam logic START_LEVEL      = 1'b0;
   localparam logic STOP_LEVEL       = 1'b1;

   // Wide enough to index any legal data width (1..16).
   localparam int   IDX_W            = 5;

endpackage

// File: rtl/bit_sync.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Both flops load PRESET on reset so the output starts at a known level.
module bit_sync #(
   parameter logic PRESET = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= PRESET;
         q    <= PRESET;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, XOR parity, stop.
// Deserialises an oversampled line and offers each word with its error flags on valid/ready.
module parity_rx
   import parity_pkg::*;
#(
   parameter int   CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int   DATA_W       = DEF_DATA_W,
   parameter logic ODD_PARITY   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_serial,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy,
   output logic [2:0]        fsm_state
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               line, line_q, fall;
   logic               sample_data, sample_par, sample_stop;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W:0]    shift_in;
   logic               acc_q, perr_q, ferr_q, done_q;

   bit_sync #(.PRESET(IDLE_LEVEL)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx_serial),
      .q     (line)
   );

   // Only a 1->0 transition starts a frame, so a held-low break cannot retrigger.
   assign fall      = line_q & ~line;
   assign shift_in  = {line, shift_q};
   assign busy      = (state_q != IDLE);
   assign fsm_state = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      sample_data = 1'b0;
      sample_par  = 1'b0;
      sample_stop = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            idx_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = (line == START_LEVEL) ? DATA : IDLE;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d       = '0;
               sample_data = 1'b1;
               idx_d       = idx_q + 1'b1;
               if (idx_q == IDX_LAST) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               sample_par = 1'b1;
               state_d    = STOP;
            end
         end
         STOP: begin
            // Leaving at mid-stop lets the next start edge be seen immediately.
            if (cnt_q == BIT_LAST) begin
               cnt_d       = '0;
               sample_stop = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake: a word transfers on any rising edge where rx_valid && rx_ready; rx_data and
   // flags hold while rx_valid && !rx_ready, and a frame finishing then is dropped (overrun).
   always_ff @(posedge clk) begin
      if (reset) begin
         line_q     <= IDLE_LEVEL;
         shift_q    <= '0;
         acc_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         line_q  <= line;
         done_q  <= sample_stop;
         overrun <= 1'b0;
         if (state_q == IDLE) acc_q <= 1'b0;
         if (sample_data) begin
            shift_q <= shift_in[DATA_W:1];
            acc_q   <= acc_q ^ line;
         end
         if (sample_par)  perr_q <= acc_q ^ line ^ ODD_PARITY;
         if (sample_stop) ferr_q <= (line != STOP_LEVEL);
         if (done_q) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_q;
               parity_err <= perr_q;
               frame_err  <= ferr_q;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: directed frames plus randomized traffic, scored against a
// frame-level model (expected words computed from data, parity bit and stop bit).
module tb_parity_rx;

   localparam int CPB = 16;
   localparam int DW  = 8;
   localparam int EW  = DW + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_serial = 1'b1;
   logic          rx_ready = 1'b1;
   logic [DW-1:0] rx_data, o_rx_data;
   logic          rx_valid, parity_err, frame_err, overrun, busy;
   logic          o_rx_valid, o_parity_err, o_frame_err, o_overrun, o_busy;
   logic [2:0]    fsm_state, o_fsm_state;

   int n_total = 0;
   int n_pass = 0;
   int n_fail = 0;
   int hs_cnt = 0;
   int valid_samples = 0;
   int overrun_cnt = 0;
   bit rand_ready = 1'b0;

   // Entry layout: {odd-parity perr, ferr, even-parity perr, data}.
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;

   parity_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ODD_PARITY(1'b0)) dut (
      .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun), .busy(busy), .fsm_state(fsm_state)
   );

   parity_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .ODD_PARITY(1'b1)) dut_odd (
      .clk(clk), .reset(reset), .rx_serial(rx_serial), .rx_data(o_rx_data),
      .rx_valid(o_rx_valid), .rx_ready(rx_ready), .parity_err(o_parity_err),
      .frame_err(o_frame_err), .overrun(o_overrun), .busy(o_busy), .fsm_state(o_fsm_state)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drivers: inputs change on the falling edge only.
   task automatic drive_bit(input logic b);
      for (int i = 0; i < CPB; i++) begin
         @(negedge clk);
         if (i == 0) rx_serial = b;
         if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop,
                             input int idle_bits, input bit expect_word);
      if (expect_word) exp_q.push_back({(^d) ^ pbit ^ 1'b1, ~stop, (^d) ^ pbit, d});
      drive_bit(1'b0);
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      drive_bit(pbit);
      drive_bit(stop);
      for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every handshake must match the head of the expected queue.
   always @(negedge clk) begin
      #1;
      if (overrun) overrun_cnt++;
      if (!reset && rx_valid) valid_samples++;
      if (!reset && rx_valid && rx_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(rx_data), 32'hdead);
         end else begin
            mon_e = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(mon_e[DW-1:0]));
            check("parity_err", 32'(parity_err), 32'(mon_e[DW]));
            check("frame_err", 32'(frame_err), 32'(mon_e[DW+1]));
            check("odd_rx_valid", 32'(o_rx_valid), 32'd1);
            check("odd_rx_data", 32'(o_rx_data), 32'(mon_e[DW-1:0]));
            check("odd_parity_err", 32'(o_parity_err), 32'(mon_e[DW+2]));
         end
      end
   end

   initial begin
      int hs0, vs0, ov0;
      logic [DW-1:0] d;
      logic pbit, stop;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Clean frame, valid for a single cycle with ready held high
      vs0 = valid_samples;
      send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1);
      wait_drain("t1_drain");
      check("t1_valid_cycles", 32'(valid_samples - vs0), 32'd1);

      // Wrong even parity, which is correct odd parity
      send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1);
      wait_drain("t2_drain");

      // Stop bit low, then a clean frame
      send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1);
      send_frame(8'h01, 1'b1, 1'b1, 1, 1'b1);
      wait_drain("t3_drain");

      // Short glitch is rejected
      hs0 = hs_cnt;
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (4) @(negedge clk);
      check("t4_glitch_busy", 32'(busy), 32'd1);
      rx_serial = 1'b1;
      repeat (10) @(negedge clk);
      check("t4_glitch_idle", 32'(busy), 32'd0);
      repeat (CPB) @(negedge clk);
      check("t4_glitch_no_word", 32'(hs_cnt - hs0), 32'd0);

      // Break held low: one framing-error word only
      hs0 = hs_cnt;
      send_frame(8'h00, 1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 19; i++) drive_bit(1'b0);
      for (int i = 0; i < 2; i++) drive_bit(1'b1);
      wait_drain("t4_break_drain");
      check("t4_break_words", 32'(hs_cnt - hs0), 32'd1);

      // Overrun: second back-to-back frame is dropped while ready is low
      @(negedge clk);
      rx_ready = 1'b0;
      ov0 = overrun_cnt;
      send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b1);
      send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0);
      check("t5_overrun_pulses", 32'(overrun_cnt - ov0), 32'd1);
      check("t5_held_valid", 32'(rx_valid), 32'd1);
      check("t5_held_data", 32'(rx_data), 32'h3C);
      check("t5_held_flags", 32'({parity_err, frame_err}), 32'd0);
      rx_ready = 1'b1;
      @(negedge clk);
      check("t5_valid_drop", 32'(rx_valid), 32'd0);
      check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of data bit 3
      hs0 = hs_cnt;
      vs0 = valid_samples;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      repeat (8) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_outputs", 32'({rx_valid, parity_err, frame_err, overrun}), 32'd0);
      check("t6_rx_data", 32'(rx_data), 32'd0);
      for (int i = 0; i < 12; i++) drive_bit(1'b1);
      check("t6_no_word", 32'(hs_cnt - hs0), 32'd0);
      check("t6_no_valid", 32'(valid_samples - vs0), 32'd0);
      send_frame(8'h0F, 1'b0, 1'b1, 1, 1'b1);
      wait_drain("t6_drain");

      // Randomized traffic with a randomly stalling consumer
      rand_ready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         d    = DW'($urandom);
         pbit = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
         stop = ($urandom_range(0, 5) != 0);
         send_frame(d, pbit, stop, $urandom_range(1, 2), 1'b1);
      end
      rand_ready = 1'b0;
      @(negedge clk);
      rx_ready = 1'b1;
      wait_drain("rand_drain");
      check("overrun_total", 32'(overrun_cnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
